vec_mat_prod_seq: RTL and testbench
===================================

// Module: vec_mat_prod_seq
// PURPOSE
//  Time-multiplexed fixed-point vector x matrix product: result = relu?(vec * mat + bias).
//  Replaces the fully parallel combinational dot-product array in inference layers.
//  NUM_LANES MAC lanes sweep column groups, trading latency for area.
//  Adds bias, rounding, saturation with overflow flag, optional ReLU and a start/busy/done handshake.
// PARAMETERS
//  FRACTION_WIDTH  15  fractional bits of signed two's-complement Q format
//  BIT_WIDTH       32  width of every operand and result element
//  NUM_COL_VEC     5   vector length = matrix rows (K)
//  NUM_COL_MAT     5   matrix columns = result length (N)
//  NUM_LANES       2   parallel MAC lanes, 1..NUM_COL_MAT
// PORTS
//  clk       in   1                      single clock, rising edge
//  rst_n     in   1                      asynchronous active-low reset
//  start     in   1                      request; accepted only in IDLE
//  relu_en   in   1                      sampled with start; 1 = clamp negative results to 0
//  vec_in    in   BIT_WIDTH x K          vector operand, sampled on accepted start
//  mat_in    in   BIT_WIDTH x K x N      matrix operand [row][col], sampled on accepted start
//  bias_in   in   BIT_WIDTH x N          per-column bias (Q format), sampled on accepted start
//  result    out  BIT_WIDTH x N          product; updated only when done pulses
//  busy      out  1                      high from the cycle after an accepted start until done
//  done      out  1                      one-cycle pulse; result valid from this cycle
//  overflow  out  1                      sticky; any column saturated in the last operation
// BEHAVIOUR
//  Reset: all outputs 0, operand and accumulator registers 0, FSM to IDLE.
//  rst_n low mid-operation aborts immediately; no done is issued.
//  FSM IDLE -> LOAD -> (MAC -> WRITE) x G -> DONE -> IDLE, with G = ceil(N/NUM_LANES).
//  IDLE: start=1 captures operands and relu_en, clears overflow, goes to LOAD.
//  start while not IDLE is ignored (no queueing).
//  LOAD: clear accumulators, row counter k=0, group counter g=0.
//  MAC: K cycles; lane l accumulates vec[k]*mat[k][g*NUM_LANES+l]; k wraps to 0 after K-1.
//  WRITE: 1 cycle; each active lane finalises its column into the internal result buffer.
//    Then either g++ -> MAC, or DONE after the last group.
//  Lanes with column index >= N in the last partial group are gated: no accumulate, no write.
//  DONE: copy the buffer to result, pulse done, busy=0, return to IDLE.
//    A start in the cycle after DONE is accepted.
//  Latency, accepted start -> done: 2 + G*(K+1) cycles. Defaults give 20.
//  result holds its value from done until the next done.
//  Arithmetic:
//    product is 2*BIT_WIDTH signed.
//    accumulator is 2*BIT_WIDTH+$clog2(K)+1 signed, so it cannot wrap.
//    bias is sign-extended and shifted left FRACTION_WIDTH, then added at WRITE.
//  Finalise: add 2^(FRACTION_WIDTH-1) (round half up), arithmetic shift right FRACTION_WIDTH,
//    saturate to [-2^(BW-1), 2^(BW-1)-1], setting overflow on clip.
//  ReLU is applied after saturation.
// STRUCTURE
//  Package vmp_pkg holds:
//    state_t enum {IDLE, LOAD, MAC, WRITE, DONE}
//    localparams ACC_W and NUM_GROUPS
//    function round_sat(acc) -> {ovf, BIT_WIDTH value}
//  Sub-module vmp_mac_lane (one per lane, generate loop) holds:
//    multiplier, accumulator and clear/enable inputs
//    finalise logic with bias and ReLU
//  Top holds the FSM, k/g counters, operand registers and result buffer.
// TESTING
//  Defaults. vec all 0x00008000 (1.0), mat all 0x00004000 (0.5), bias 0
//    -> every result 0x00014000 (2.5), done at cycle 20, overflow=0.
//  vec all 0xFFFF8000 (-1.0), mat all 0x00008000, relu_en=0 -> every result 0xFFFD8000 (-5.0).
//    Same with relu_en=1 -> every result 0.
//  vec, mat all 0x7FFFFFFF -> every result 0x7FFFFFFF, overflow=1.
//    A following clean run clears overflow.
//  vec[0]=1, other vec 0, mat row 0 = 0x00004000, bias[2]=0x00002000
//    -> results 1,1,0x2001,1,1 (rounding + bias).
//  N=5, NUM_LANES=3 (partial group): random operands vs. golden model; done at cycle 14.
//    Gated lane writes nothing.
//  start pulsed during MAC is ignored.
//    rst_n low at cycle 8: outputs 0, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/vmp_pkg.sv
// Shared types and fixed-point helpers for the sequential vector x matrix product.
// Default widths live here; round_sat is built on these default operand and accumulator widths.
package vmp_pkg;

    localparam int DEF_FRACTION_WIDTH = 15;
    localparam int DEF_BIT_WIDTH      = 32;
    localparam int DEF_NUM_COL_VEC    = 5;
    localparam int DEF_NUM_COL_MAT    = 5;
    localparam int DEF_NUM_LANES      = 2;

    localparam int ACC_W      = 2 * DEF_BIT_WIDTH + $clog2(DEF_NUM_COL_VEC) + 1;
    localparam int NUM_GROUPS = (DEF_NUM_COL_MAT + DEF_NUM_LANES - 1) / DEF_NUM_LANES;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (DEF_FRACTION_WIDTH - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DEF_BIT_WIDTH + 1){1'b0}}, {(DEF_BIT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DEF_BIT_WIDTH + 1){1'b1}}, {(DEF_BIT_WIDTH - 1){1'b0}}};

    // Round half up, drop the fraction bits, clip to the operand range: {overflow, value}.
    function automatic logic [DEF_BIT_WIDTH:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = (acc + ROUND_HALF) >>> DEF_FRACTION_WIDTH;
        if (shifted > SAT_MAX) begin
            return {1'b1, SAT_MAX[DEF_BIT_WIDTH-1:0]};
        end else if (shifted < SAT_MIN) begin
            return {1'b1, SAT_MIN[DEF_BIT_WIDTH-1:0]};
        end
        return {1'b0, shifted[DEF_BIT_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/vmp_mac_lane.sv
// One MAC lane: multiplies and accumulates one result column, then finalises it
// with bias, rounding, saturation and optional ReLU.
module vmp_mac_lane
    import vmp_pkg::*;
#(
    parameter int BIT_WIDTH      = DEF_BIT_WIDTH,
    parameter int FRACTION_WIDTH = DEF_FRACTION_WIDTH,
    parameter int NUM_COL_VEC    = DEF_NUM_COL_VEC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 acc_en_i,
    input  logic                 relu_en_i,
    input  logic [BIT_WIDTH-1:0] vec_i,
    input  logic [BIT_WIDTH-1:0] mat_i,
    input  logic [BIT_WIDTH-1:0] bias_i,
    output logic [BIT_WIDTH-1:0] value_o,
    output logic                 ovf_o
);

    localparam int LANE_ACC_W = 2 * BIT_WIDTH + $clog2(NUM_COL_VEC) + 1;

    logic signed [2*BIT_WIDTH-1:0] product;
    logic signed [LANE_ACC_W-1:0]  acc_q;
    logic signed [LANE_ACC_W-1:0]  biasExt;
    logic signed [LANE_ACC_W-1:0]  total;
    logic        [BIT_WIDTH-1:0]   sat;
    logic                          satOvf;

    assign product = $signed(vec_i) * $signed(mat_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= acc_q + $signed({{(LANE_ACC_W - 2*BIT_WIDTH){product[2*BIT_WIDTH-1]}}, product});
        end
    end

    // Bias is in the operand Q format, so align it with the double-width product fraction.
    assign biasExt = $signed({{(LANE_ACC_W - BIT_WIDTH){bias_i[BIT_WIDTH-1]}}, bias_i}) <<< FRACTION_WIDTH;
    assign total   = acc_q + biasExt;

    assign {satOvf, sat} = round_sat(total);
    assign ovf_o   = satOvf;
    assign value_o = (relu_en_i && sat[BIT_WIDTH-1]) ? '0 : sat;

endmodule

// File: rtl/vec_mat_prod_seq.sv
// Time-multiplexed fixed-point vector x matrix product with bias, rounding, saturation
// and optional ReLU; NUM_LANES MAC lanes sweep the result columns group by group.
module vec_mat_prod_seq
    import vmp_pkg::*;
#(
    parameter int FRACTION_WIDTH = DEF_FRACTION_WIDTH,
    parameter int BIT_WIDTH      = DEF_BIT_WIDTH,
    parameter int NUM_COL_VEC    = DEF_NUM_COL_VEC,
    parameter int NUM_COL_MAT    = DEF_NUM_COL_MAT,
    parameter int NUM_LANES      = DEF_NUM_LANES
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start,
    input  logic                                            relu_en,
    input  logic [NUM_COL_VEC-1:0][BIT_WIDTH-1:0]           vec_in,
    input  logic [NUM_COL_VEC-1:0][NUM_COL_MAT-1:0][BIT_WIDTH-1:0] mat_in,
    input  logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0]           bias_in,
    output logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0]           result,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            overflow
);

    localparam int GROUPS = (NUM_COL_MAT + NUM_LANES - 1) / NUM_LANES;
    localparam int KW     = (NUM_COL_VEC > 1) ? $clog2(NUM_COL_VEC) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int IW     = (NUM_COL_MAT > 1) ? $clog2(NUM_COL_MAT) : 1;
    localparam int CW     = $clog2(NUM_COL_MAT + NUM_LANES) + 1;

    state_t                                            state_q;
    logic [KW-1:0]                                     k_q;
    logic [GW-1:0]                                     g_q;
    logic [NUM_COL_VEC-1:0][BIT_WIDTH-1:0]             vec_q;
    logic [NUM_COL_VEC-1:0][NUM_COL_MAT-1:0][BIT_WIDTH-1:0] mat_q;
    logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0]             bias_q;
    logic                                              relu_q;
    logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0]             buf_q;
    logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0]             result_q;
    logic                                              busy_q;
    logic                                              done_q;
    logic                                              ovf_q;

    logic [NUM_LANES-1:0]                              laneActive;
    logic [NUM_LANES-1:0]                              laneOvf;
    logic [NUM_LANES-1:0][IW-1:0]                      laneIdx;
    logic [NUM_LANES-1:0][BIT_WIDTH-1:0]               laneVal;
    logic                                              laneClear;
    logic                                              inMac;

    assign laneClear = (state_q == LOAD) || (state_q == WRITE);
    assign inMac     = (state_q == MAC);

    // Lanes whose column falls past the last matrix column are gated off entirely.
    for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
        logic [CW-1:0] colRaw;
        assign colRaw        = CW'(g_q) * CW'(NUM_LANES) + CW'(l);
        assign laneActive[l] = colRaw < CW'(NUM_COL_MAT);
        assign laneIdx[l]    = laneActive[l] ? colRaw[IW-1:0] : '0;

        vmp_mac_lane #(
            .BIT_WIDTH      (BIT_WIDTH),
            .FRACTION_WIDTH (FRACTION_WIDTH),
            .NUM_COL_VEC    (NUM_COL_VEC)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear_i   (laneClear),
            .acc_en_i  (inMac && laneActive[l]),
            .relu_en_i (relu_q),
            .vec_i     (vec_q[k_q]),
            .mat_i     (mat_q[k_q][laneIdx[l]]),
            .bias_i    (bias_q[laneIdx[l]]),
            .value_o   (laneVal[l]),
            .ovf_o     (laneOvf[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            g_q      <= '0;
            vec_q    <= '0;
            mat_q    <= '0;
            bias_q   <= '0;
            relu_q   <= 1'b0;
            buf_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q   <= vec_in;
                        mat_q   <= mat_in;
                        bias_q  <= bias_in;
                        relu_q  <= relu_en;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    k_q     <= '0;
                    g_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    if (k_q == KW'(NUM_COL_VEC - 1)) begin
                        k_q     <= '0;
                        state_q <= WRITE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                WRITE: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (laneActive[l]) begin
                            buf_q[laneIdx[l]] <= laneVal[l];
                            if (laneOvf[l]) begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                    if (g_q == GW'(GROUPS - 1)) begin
                        state_q <= DONE;
                    end else begin
                        g_q     <= g_q + 1'b1;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    result_q <= buf_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_vec_mat_prod_seq.sv
// Directed bench for vec_mat_prod_seq: a default two-lane instance plus a three-lane
// instance that exercises the partially filled last column group.
module tb_vec_mat_prod_seq;

    localparam int BW = 32;
    localparam int K  = 5;
    localparam int N  = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic startA, startB, reluEn;
    logic [K-1:0][BW-1:0]         vecIn;
    logic [K-1:0][N-1:0][BW-1:0]  matIn;
    logic [N-1:0][BW-1:0]         biasIn;
    logic [N-1:0][BW-1:0]         resultA, resultB;
    logic busyA, doneA, ovfA, busyB, doneB, ovfB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_mat_prod_seq dutA (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startA),
        .relu_en  (reluEn),
        .vec_in   (vecIn),
        .mat_in   (matIn),
        .bias_in  (biasIn),
        .result   (resultA),
        .busy     (busyA),
        .done     (doneA),
        .overflow (ovfA)
    );

    vec_mat_prod_seq #(.NUM_LANES(3)) dutB (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startB),
        .relu_en  (reluEn),
        .vec_in   (vecIn),
        .mat_in   (matIn),
        .bias_in  (biasIn),
        .result   (resultB),
        .busy     (busyB),
        .done     (doneB),
        .overflow (ovfB)
    );

    task automatic setOperands(input logic [BW-1:0] v, input logic [BW-1:0] m, input logic [BW-1:0] b);
        for (int k = 0; k < K; k++) begin
            vecIn[k] = v;
            for (int j = 0; j < N; j++) matIn[k][j] = m;
        end
        for (int j = 0; j < N; j++) biasIn[j] = b;
    endtask

    // Pulses start for one edge, then counts edges until done (-1 if it never comes).
    task automatic runOp(input bit onB, output int lat);
        @(negedge clk);
        if (onB) startB = 1'b1; else startA = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if ((onB ? doneB : doneA) === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic logic [BW-1:0] modelCol(input int j, output bit ovf);
        logic signed [67:0] acc;
        acc = '0;
        for (int k = 0; k < K; k++) acc = acc + ($signed(vecIn[k]) * $signed(matIn[k][j]));
        acc = acc + ($signed(biasIn[j]) * 68'sd32768);
        acc = (acc + 68'sd16384) >>> 15;
        ovf = 1'b0;
        if (acc > 68'sd2147483647) begin
            ovf = 1'b1;
            return 32'h7FFF_FFFF;
        end else if (acc < -68'sd2147483648) begin
            ovf = 1'b1;
            return 32'h8000_0000;
        end
        return acc[31:0];
    endfunction

    task automatic test_reset();
        #12;
        checks++;
        if ({busyA, doneA, ovfA, busyB, doneB, ovfB} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000", {busyA, doneA, ovfA, busyB, doneB, ovfB});
        end
        checks++;
        if (resultA !== '0 || resultB !== '0) begin
            errors++;
            $display("[TB] FAIL reset_result: got %h / %h expected 0", resultA, resultB);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        setOperands(32'h0000_8000, 32'h0000_4000, 32'h0);
        reluEn = 1'b0;
        runOp(1'b0, lat);
        checks++;
        if (lat !== 20) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected 20", lat);
        end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (resultA[j] !== 32'h0001_4000) begin
                errors++;
                $display("[TB] FAIL basic_result[%0d]: got %h expected 00014000", j, resultA[j]);
            end
        end
        checks++;
        if (ovfA !== 1'b0 || busyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_flags: got ovf=%b busy=%b expected 0 0", ovfA, busyA);
        end
        @(posedge clk);
        #1;
        checks++;
        if (doneA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse: got %b expected 0", doneA);
        end
    endtask

    task automatic test_negative_relu();
        int lat;
        setOperands(32'hFFFF_8000, 32'h0000_8000, 32'h0);
        reluEn = 1'b0;
        runOp(1'b0, lat);
        for (int j = 0; j < N; j++) begin
            checks++;
            if (resultA[j] !== 32'hFFFD_8000) begin
                errors++;
                $display("[TB] FAIL negative_result[%0d]: got %h expected fffd8000", j, resultA[j]);
            end
        end
        reluEn = 1'b1;
        runOp(1'b0, lat);
        reluEn = 1'b0;
        for (int j = 0; j < N; j++) begin
            checks++;
            if (resultA[j] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL relu_result[%0d]: got %h expected 00000000", j, resultA[j]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        setOperands(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);
        runOp(1'b0, lat);
        for (int j = 0; j < N; j++) begin
            checks++;
            if (resultA[j] !== 32'h7FFF_FFFF) begin
                errors++;
                $display("[TB] FAIL sat_result[%0d]: got %h expected 7fffffff", j, resultA[j]);
            end
        end
        checks++;
        if (ovfA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_overflow: got %b expected 1", ovfA);
        end
        setOperands(32'h0000_8000, 32'h0000_4000, 32'h0);
        runOp(1'b0, lat);
        checks++;
        if (ovfA !== 1'b0 || resultA[0] !== 32'h0001_4000) begin
            errors++;
            $display("[TB] FAIL clean_after_sat: got ovf=%b r0=%h expected 0 00014000", ovfA, resultA[0]);
        end
    endtask

    task automatic test_rounding_bias();
        int lat;
        logic [BW-1:0] expected [N];
        expected = '{32'h1, 32'h1, 32'h2001, 32'h1, 32'h1};
        setOperands(32'h0, 32'h0, 32'h0);
        vecIn[0]  = 32'h1;
        for (int j = 0; j < N; j++) matIn[0][j] = 32'h0000_4000;
        biasIn[2] = 32'h0000_2000;
        runOp(1'b0, lat);
        for (int j = 0; j < N; j++) begin
            checks++;
            if (resultA[j] !== expected[j]) begin
                errors++;
                $display("[TB] FAIL round_bias[%0d]: got %h expected %h", j, resultA[j], expected[j]);
            end
        end
    endtask

    task automatic test_partial_group();
        int lat;
        bit colOvf;
        bit anyOvf;
        logic [BW-1:0] expected;
        for (int k = 0; k < K; k++) begin
            vecIn[k] = 32'($urandom_range(0, 32'h0080_0000)) - 32'h0040_0000;
            for (int j = 0; j < N; j++) matIn[k][j] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
        end
        for (int j = 0; j < N; j++) biasIn[j] = 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
        anyOvf = 1'b0;
        runOp(1'b1, lat);
        checks++;
        if (lat !== 14) begin
            errors++;
            $display("[TB] FAIL partial_latency: got %0d expected 14", lat);
        end
        for (int j = 0; j < N; j++) begin
            expected = modelCol(j, colOvf);
            anyOvf |= colOvf;
            checks++;
            if (resultB[j] !== expected) begin
                errors++;
                $display("[TB] FAIL partial_result[%0d]: got %h expected %h", j, resultB[j], expected);
            end
        end
        checks++;
        if (ovfB !== anyOvf) begin
            errors++;
            $display("[TB] FAIL partial_overflow: got %b expected %b", ovfB, anyOvf);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int extraDone;
        setOperands(32'h0000_8000, 32'h0000_4000, 32'h0);
        @(negedge clk);
        startA = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            startA = 1'b0;
            if (c == 8) begin
                checks++;
                if (busyA !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL busy_mid_op: got %b expected 1", busyA);
                end
                startA = 1'b1;
                for (int k = 0; k < K; k++) vecIn[k] = 32'h7FFF_FFFF;
            end
            if (doneA === 1'b1) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 20 || resultA[3] !== 32'h0001_4000 || ovfA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_ignored: got lat=%0d r3=%h ovf=%b expected 20 00014000 0", lat, resultA[3], ovfA);
        end
        extraDone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (doneA === 1'b1) extraDone++;
        end
        checks++;
        if (extraDone !== 0) begin
            errors++;
            $display("[TB] FAIL start_queued: got %0d extra done pulses expected 0", extraDone);
        end
        setOperands(32'h0000_8000, 32'h0000_4000, 32'h0);
    endtask

    task automatic test_reset_abort();
        int lat;
        int doneSeen;
        setOperands(32'h0000_8000, 32'h0000_4000, 32'h0);
        @(negedge clk);
        startA = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resultA !== '0 || {busyA, doneA, ovfA} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got r0=%h flags=%b expected 0 000", resultA[0], {busyA, doneA, ovfA});
        end
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (doneA === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin
            errors++;
            $display("[TB] FAIL abort_done: got %0d done pulses expected 0", doneSeen);
        end
        runOp(1'b0, lat);
        checks++;
        if (lat !== 20 || resultA[4] !== 32'h0001_4000) begin
            errors++;
            $display("[TB] FAIL after_abort: got lat=%0d r4=%h expected 20 00014000", lat, resultA[4]);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        reluEn = 1'b0;
        setOperands(32'h0, 32'h0, 32'h0);
        test_reset();
        test_basic();
        test_negative_relu();
        test_saturation();
        test_rounding_bias();
        test_partial_group();
        test_start_ignored();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
